id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register for the RISC-V core.
- Takes decode-stage fields and the register file's combinational RD1/RD2 read data, and resolves operand bypassing from the EX, MEM and WB stages.
- Detects load-use hazards and registers a clean operand/control bundle for the execute stage.
- Generates the decode/fetch stall and inserts bubbles; keeps a bubble counter for performance debug.

Parameters:
- DATA_WIDTH, 32, operand/result width
- ADDRESS_WIDTH, 5, register index width
- CTRL_WIDTH, 8, opaque execute control bundle (ALU op, alu_src, etc.), passed through unmodified

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  decode holds a valid instruction
- id_rs1, id_rs2  in  ADDRESS_WIDTH  source register indices (drive register file AD1/AD2)
- id_uses_rs1, id_uses_rs2  in  1  instruction actually reads rs1/rs2
- id_rd  in  ADDRESS_WIDTH  destination index
- id_reg_write, id_mem_read  in  1  writes rd / is a load
- id_ctrl  in  CTRL_WIDTH  opaque execute controls
- id_pc, id_imm  in  DATA_WIDTH  PC and sign-extended immediate
- rf_rd1, rf_rd2  in  DATA_WIDTH  register file read data
- ex_result  in  DATA_WIDTH  ALU result of the instruction currently held in this stage
- mem_rd  in  ADDRESS_WIDTH  MEM-stage destination
- mem_reg_write  in  1  MEM-stage instruction writes rd
- mem_result  in  DATA_WIDTH  MEM-stage final value (load data for loads)
- wb_rd  in  ADDRESS_WIDTH  WB destination (same as register file AD3)
- wb_we  in  1  WB write enable (same as WE3)
- wb_data  in  DATA_WIDTH  WB data (same as WD3)
- flush  in  1  branch/jump redirect: kill the decode instruction
- ex_hold  in  1  execute stage cannot accept; freeze this stage
- stall_out  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  registered valid
- ex_op1, ex_op2  out  DATA_WIDTH  registered, bypass-resolved rs1/rs2 values
- ex_rd  out  ADDRESS_WIDTH  registered destination
- ex_reg_write, ex_mem_read  out  1  registered controls
- ex_ctrl  out  CTRL_WIDTH  registered opaque controls
- ex_pc, ex_imm  out  DATA_WIDTH  registered PC and immediate
- bubble_count  out  32  count of bubbles inserted by load-use

Behaviour:
- **Reset** (asynchronous, active-high): all outputs and registers are 0; ex_valid=0 and bubble_count=0 immediately.
- **Bypass:** computed per operand, combinationally, in the cycle the operand is captured. Priority is:
  1. EX: ex_valid & ex_reg_write & !ex_mem_read & ex_rd==rs → ex_result
  2. MEM: mem_reg_write & mem_rd==rs → mem_result
  3. WB: wb_we & wb_rd==rs → wb_data
  4. otherwise rf_rdN
- A source index of 0 never bypasses; the operand is rf_rdN, which reads 0.
- The WB bypass is mandatory: the register file writes at the clock edge, so a same-cycle read returns the old value.
- **Load-use hazard:** load_use = id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)).
- **Next-state priority**, on each rising edge:
  1. rst (asynchronous) clears the stage.
  2. ex_hold=1: all registers keep their value, including through flush; flush must be reasserted by its source.
  3. flush=1: ex_valid←0; other fields are don't-care but must be kept stable.
  4. load_use=1: ex_valid←0 (bubble) and bubble_count increments, wrapping at 2^32−1→0.
  5. Otherwise: load all fields; ex_valid←id_valid.
- stall_out = ex_hold | (load_use & !flush).
- Latency: 1 cycle from decode to ex_* outputs.
- A load-use stall lasts exactly 1 cycle. The next cycle the load is in MEM and is resolved via mem_result.
- An invalid decode slot (id_valid=0) never raises load_use.

Decomposition:
- **Package** rv_pipe_pkg:
  - enum fwd_sel_e {FWD_RF, FWD_WB, FWD_MEM, FWD_EX}
  - localparams XLEN=32 and REG_ADDR_W=5
- **Sub-module** operand_bypass: combinational priority mux, one operand. Inputs are rs, uses, the three source tuples and rf data; outputs are data and fwd_sel_e. Instantiated twice.

Test Plan:
- **Plain pass-through:** rs1=3, rs2=4, rf_rd1=0x11, rf_rd2=0x22, no matches → next edge ex_op1=0x11, ex_op2=0x22, ex_valid=1, stall_out=0.
- **Bypass priority:**
  - With rs1=5 and EX, MEM and WB all targeting x5 (ex_result=0xA, mem_result=0xB, wb_data=0xC) → ex_op1=0xA.
  - Drop EX → 0xB.
  - Drop MEM → 0xC.
  - rs1=0 with all sources targeting x0 → ex_op1=rf_rd1=0.
- **Load-use:** EX holds a lw into x7; decode add uses rs2=7 → stall_out=1, one bubble (ex_valid=0), bubble_count=1. Next cycle with mem_result=0x55 → ex_op2=0x55, stall_out=0.
- **Flush vs load-use:** same hazard plus flush=1 → stall_out=0, ex_valid=0, bubble_count unchanged.
- **ex_hold:** assert for 3 cycles with changing decode inputs → all ex_* outputs frozen and stall_out=1. On release the pending decode is captured.
- **Reset and counter wrap:**
  - Assert rst mid-stream, asynchronously between edges → ex_valid and bubble_count drop to 0 before the next edge.
  - Preload bubble_count=0xFFFFFFFF by forcing, then trigger a load-use → bubble_count=0.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// Shared types and widths for the RISC-V pipeline slice.
// Operand source selection is ordered from oldest (register file) to youngest (EX).
package rv_pipe_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_EX  = 2'd3
    } fwd_sel_e;
endpackage

// File: rtl/operand_bypass.sv
// One-operand bypass mux: picks the youngest in-flight producer of rs, else register file data.
module operand_bypass
    import rv_pipe_pkg::*;
#(
    parameter int DATA_WIDTH    = XLEN,
    parameter int ADDRESS_WIDTH = REG_ADDR_W
) (
    input  logic [ADDRESS_WIDTH-1:0] rs,
    input  logic                     uses,
    input  logic                     ex_en,
    input  logic [ADDRESS_WIDTH-1:0] ex_rd,
    input  logic [DATA_WIDTH-1:0]    ex_data,
    input  logic                     mem_en,
    input  logic [ADDRESS_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0]    mem_data,
    input  logic                     wb_en,
    input  logic [ADDRESS_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0]    wb_data,
    input  logic [DATA_WIDTH-1:0]    rf_data,
    output logic [DATA_WIDTH-1:0]    data,
    output fwd_sel_e                 sel
);

    // x0 is hardwired to zero, so a producer targeting it is never forwarded.
    always_comb begin
        sel = FWD_RF;
        if (uses && (rs != '0)) begin
            if (ex_en && (ex_rd == rs)) begin
                sel = FWD_EX;
            end else if (mem_en && (mem_rd == rs)) begin
                sel = FWD_MEM;
            end else if (wb_en && (wb_rd == rs)) begin
                sel = FWD_WB;
            end
        end
    end

    always_comb begin
        data = rf_data;
        case (sel)
            FWD_EX:  data = ex_data;
            FWD_MEM: data = mem_data;
            FWD_WB:  data = wb_data;
            default: data = rf_data;
        endcase
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand bypassing, load-use bubble insertion and stall generation.
// bubble_count tallies inserted load-use bubbles for performance debug.
module id_ex_operand_stage
    import rv_pipe_pkg::*;
#(
    parameter int DATA_WIDTH    = XLEN,
    parameter int ADDRESS_WIDTH = REG_ADDR_W,
    parameter int CTRL_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic [ADDRESS_WIDTH-1:0] id_rs1,
    input  logic [ADDRESS_WIDTH-1:0] id_rs2,
    input  logic                     id_uses_rs1,
    input  logic                     id_uses_rs2,
    input  logic [ADDRESS_WIDTH-1:0] id_rd,
    input  logic                     id_reg_write,
    input  logic                     id_mem_read,
    input  logic [CTRL_WIDTH-1:0]    id_ctrl,
    input  logic [DATA_WIDTH-1:0]    id_pc,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic [DATA_WIDTH-1:0]    rf_rd1,
    input  logic [DATA_WIDTH-1:0]    rf_rd2,
    input  logic [DATA_WIDTH-1:0]    ex_result,
    input  logic [ADDRESS_WIDTH-1:0] mem_rd,
    input  logic                     mem_reg_write,
    input  logic [DATA_WIDTH-1:0]    mem_result,
    input  logic [ADDRESS_WIDTH-1:0] wb_rd,
    input  logic                     wb_we,
    input  logic [DATA_WIDTH-1:0]    wb_data,
    input  logic                     flush,
    input  logic                     ex_hold,
    output logic                     stall_out,
    output logic                     ex_valid,
    output logic [DATA_WIDTH-1:0]    ex_op1,
    output logic [DATA_WIDTH-1:0]    ex_op2,
    output logic [ADDRESS_WIDTH-1:0] ex_rd,
    output logic                     ex_reg_write,
    output logic                     ex_mem_read,
    output logic [CTRL_WIDTH-1:0]    ex_ctrl,
    output logic [DATA_WIDTH-1:0]    ex_pc,
    output logic [DATA_WIDTH-1:0]    ex_imm,
    output logic [31:0]              bubble_count
);

    logic                  ex_fwd_en;
    logic                  load_use;
    logic [DATA_WIDTH-1:0] op1_next;
    logic [DATA_WIDTH-1:0] op2_next;
    fwd_sel_e              fwd_sel_rs1;
    fwd_sel_e              fwd_sel_rs2;
    logic [3:0]            fwd_sel_unused;
    logic [31:0]           bubble_count_q;

    // A load in EX has no data yet; that case is a load-use bubble, not a bypass.
    assign ex_fwd_en = ex_valid & ex_reg_write & ~ex_mem_read;

    assign load_use = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
                      ((id_uses_rs1 & (ex_rd == id_rs1)) |
                       (id_uses_rs2 & (ex_rd == id_rs2)));

    assign stall_out = ex_hold | (load_use & ~flush);

    operand_bypass #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_bypass_rs1 (
        .rs      (id_rs1),
        .uses    (id_uses_rs1),
        .ex_en   (ex_fwd_en),
        .ex_rd   (ex_rd),
        .ex_data (ex_result),
        .mem_en  (mem_reg_write),
        .mem_rd  (mem_rd),
        .mem_data(mem_result),
        .wb_en   (wb_we),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
        .rf_data (rf_rd1),
        .data    (op1_next),
        .sel     (fwd_sel_rs1)
    );

    operand_bypass #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_bypass_rs2 (
        .rs      (id_rs2),
        .uses    (id_uses_rs2),
        .ex_en   (ex_fwd_en),
        .ex_rd   (ex_rd),
        .ex_data (ex_result),
        .mem_en  (mem_reg_write),
        .mem_rd  (mem_rd),
        .mem_data(mem_result),
        .wb_en   (wb_we),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
        .rf_data (rf_rd2),
        .data    (op2_next),
        .sel     (fwd_sel_rs2)
    );

    // Source selects are kept for debug probing only.
    assign fwd_sel_unused = {fwd_sel_rs1, fwd_sel_rs2};

    // Flush and bubbles only clear valid; payload fields hold so they stay stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid       <= 1'b0;
            ex_op1         <= '0;
            ex_op2         <= '0;
            ex_rd          <= '0;
            ex_reg_write   <= 1'b0;
            ex_mem_read    <= 1'b0;
            ex_ctrl        <= '0;
            ex_pc          <= '0;
            ex_imm         <= '0;
            bubble_count_q <= '0;
        end else if (!ex_hold) begin
            if (flush) begin
                ex_valid <= 1'b0;
            end else if (load_use) begin
                ex_valid       <= 1'b0;
                bubble_count_q <= bubble_count_q + 32'd1;
            end else begin
                ex_valid     <= id_valid;
                ex_op1       <= op1_next;
                ex_op2       <= op2_next;
                ex_rd        <= id_rd;
                ex_reg_write <= id_reg_write;
                ex_mem_read  <= id_mem_read;
                ex_ctrl      <= id_ctrl;
                ex_pc        <= id_pc;
                ex_imm       <= id_imm;
            end
        end
    end

    assign bubble_count = bubble_count_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: driver predicts each edge's outcome, monitor compares.
// The reference resolves operands by searching in-flight producers youngest-first.
module tb_id_ex_operand_stage;

    typedef struct {
        bit          rst;
        bit          id_valid;
        logic [4:0]  rs1, rs2, rd;
        bit          u1, u2, rw, mr;
        logic [7:0]  ctrl;
        logic [31:0] pc, imm, rf1, rf2, exr;
        logic [4:0]  mem_rd, wb_rd;
        bit          mem_we, wb_we;
        logic [31:0] mem_res, wb_dat;
        bit          flush, hold, preload;
    } stim_t;

    typedef struct {
        bit          valid;
        logic [4:0]  rd;
        bit          rw, mr;
        logic [7:0]  ctrl;
        logic [31:0] pc, imm, op1, op2;
        bit          k1, k2;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic        id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
    logic        id_reg_write = 1'b0, id_mem_read = 1'b0;
    logic [7:0]  id_ctrl = '0;
    logic [31:0] id_pc = '0, id_imm = '0, rf_rd1 = '0, rf_rd2 = '0, ex_result = '0;
    logic [4:0]  mem_rd = '0, wb_rd = '0;
    logic        mem_reg_write = 1'b0, wb_we = 1'b0;
    logic [31:0] mem_result = '0, wb_data = '0;
    logic        flush = 1'b0, ex_hold = 1'b0;
    logic        stall_out, ex_valid, ex_reg_write, ex_mem_read;
    logic [31:0] ex_op1, ex_op2, ex_pc, ex_imm, bubble_count;
    logic [4:0]  ex_rd;
    logic [7:0]  ex_ctrl;

    int   n_checks = 0;
    int   n_err = 0;
    exp_t m;
    exp_t exp_q[$];
    logic stall_seen;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_ctrl(id_ctrl),
        .id_pc(id_pc), .id_imm(id_imm), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .ex_result(ex_result), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_result(mem_result), .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
        .flush(flush), .ex_hold(ex_hold), .stall_out(stall_out), .ex_valid(ex_valid),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .bubble_count(bubble_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t reset_state();
        exp_t r;
        r.valid = 0; r.rd = '0; r.rw = 0; r.mr = 0; r.ctrl = '0; r.pc = '0; r.imm = '0;
        r.op1 = '0; r.op2 = '0; r.k1 = 1; r.k2 = 1; r.cnt = '0;
        return r;
    endfunction

    // Youngest producer of rs wins; x0 always reads the register file.
    function automatic logic [31:0] resolve(input stim_t s, input exp_t e, input bit second);
        logic [4:0]  rs;
        logic [31:0] rf;
        bit          en [3];
        logic [4:0]  prd [3];
        logic [31:0] val [3];
        rs = second ? s.rs2 : s.rs1;
        rf = second ? s.rf2 : s.rf1;
        en[0] = e.valid && e.rw && !e.mr; prd[0] = e.rd;     val[0] = s.exr;
        en[1] = s.mem_we;                 prd[1] = s.mem_rd; val[1] = s.mem_res;
        en[2] = s.wb_we;                  prd[2] = s.wb_rd;  val[2] = s.wb_dat;
        if (rs == 5'd0) return rf;
        for (int i = 0; i < 3; i++)
            if (en[i] && prd[i] == rs) return val[i];
        return rf;
    endfunction

    function automatic stim_t quiet();
        stim_t s;
        s.rst = 0; s.id_valid = 0; s.rs1 = '0; s.rs2 = '0; s.rd = '0;
        s.u1 = 0; s.u2 = 0; s.rw = 0; s.mr = 0; s.ctrl = '0; s.pc = '0; s.imm = '0;
        s.rf1 = '0; s.rf2 = '0; s.exr = '0; s.mem_rd = '0; s.wb_rd = '0;
        s.mem_we = 0; s.wb_we = 0; s.mem_res = '0; s.wb_dat = '0;
        s.flush = 0; s.hold = 0; s.preload = 0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s = quiet();
        s.rst = ($urandom_range(99) == 0);
        s.id_valid = ($urandom_range(3) != 0);
        s.rs1 = 5'($urandom_range(7)); s.rs2 = 5'($urandom_range(7)); s.rd = 5'($urandom_range(7));
        s.u1 = $urandom_range(3) != 0; s.u2 = $urandom_range(1) != 0;
        s.mr = $urandom_range(2) == 0; s.rw = s.mr || ($urandom_range(1) != 0);
        s.ctrl = 8'($urandom); s.pc = $urandom; s.imm = $urandom;
        s.rf1 = (s.rs1 == 0) ? 32'd0 : $urandom;
        s.rf2 = (s.rs2 == 0) ? 32'd0 : $urandom;
        s.exr = $urandom;
        s.mem_rd = 5'($urandom_range(7)); s.mem_we = $urandom_range(1) != 0; s.mem_res = $urandom;
        s.wb_rd = 5'($urandom_range(7));  s.wb_we = $urandom_range(1) != 0;  s.wb_dat = $urandom;
        s.flush = $urandom_range(9) == 0; s.hold = $urandom_range(9) == 0;
        return s;
    endfunction

    // Apply one cycle of stimulus, check stall, predict the edge and queue the expectation.
    task automatic drive_cycle(input stim_t s);
        bit lu;
        bit exp_stall;
        @(negedge clk);
        rst = s.rst; id_valid = s.id_valid; id_rs1 = s.rs1; id_rs2 = s.rs2;
        id_uses_rs1 = s.u1; id_uses_rs2 = s.u2; id_rd = s.rd; id_reg_write = s.rw;
        id_mem_read = s.mr; id_ctrl = s.ctrl; id_pc = s.pc; id_imm = s.imm;
        rf_rd1 = s.rf1; rf_rd2 = s.rf2; ex_result = s.exr;
        mem_rd = s.mem_rd; mem_reg_write = s.mem_we; mem_result = s.mem_res;
        wb_rd = s.wb_rd; wb_we = s.wb_we; wb_data = s.wb_dat;
        flush = s.flush; ex_hold = s.hold;
        #1;
        if (s.preload) begin
            force dut.bubble_count_q = 32'hFFFF_FFFF;
            #1;
            release dut.bubble_count_q;
            m.cnt = 32'hFFFF_FFFF;
        end
        if (s.rst) begin
            m = reset_state();
            chk("async_rst_valid", {31'd0, ex_valid}, 32'd0);
            chk("async_rst_bubbles", bubble_count, 32'd0);
        end
        lu = s.id_valid && m.valid && m.mr && (m.rd != 0) &&
             ((s.u1 && m.rd == s.rs1) || (s.u2 && m.rd == s.rs2));
        exp_stall = s.hold || (lu && !s.flush);
        stall_seen = stall_out;
        chk("stall_out", {31'd0, stall_out}, {31'd0, exp_stall});
        if (!s.rst && !s.hold) begin
            if (s.flush) begin
                m.valid = 0;
            end else if (lu) begin
                m.valid = 0;
                m.cnt = m.cnt + 1;
            end else begin
                m.op1 = resolve(s, m, 0); m.k1 = s.u1;
                m.op2 = resolve(s, m, 1); m.k2 = s.u2;
                m.valid = s.id_valid; m.rd = s.rd; m.rw = s.rw; m.mr = s.mr;
                m.ctrl = s.ctrl; m.pc = s.pc; m.imm = s.imm;
            end
        end
        exp_q.push_back(m);
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
            chk("bubble_count", bubble_count, e.cnt);
            chk("ex_rd", {27'd0, ex_rd}, {27'd0, e.rd});
            chk("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, e.rw});
            chk("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, e.mr});
            chk("ex_ctrl", {24'd0, ex_ctrl}, {24'd0, e.ctrl});
            chk("ex_pc", ex_pc, e.pc);
            chk("ex_imm", ex_imm, e.imm);
            if (e.k1) chk("ex_op1", ex_op1, e.op1);
            if (e.k2) chk("ex_op2", ex_op2, e.op2);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        m = reset_state();
        #1;
        chk("reset_valid", {31'd0, ex_valid}, 32'd0);
        chk("reset_bubbles", bubble_count, 32'd0);
        s = quiet(); s.rst = 1;
        drive_cycle(s);

        // Plain pass-through; the instruction writes x5 so it can act as the EX producer next.
        s = quiet(); s.id_valid = 1; s.rs1 = 3; s.rs2 = 4; s.u1 = 1; s.u2 = 1;
        s.rf1 = 32'h11; s.rf2 = 32'h22; s.rd = 5; s.rw = 1; s.pc = 32'h100;
        drive_cycle(s);
        chk("pass_stall", {31'd0, stall_seen}, 32'd0);
        chk("pass_op1", ex_op1, 32'h11);
        chk("pass_op2", ex_op2, 32'h22);
        chk("pass_valid", {31'd0, ex_valid}, 32'd1);

        // Bypass priority on rs1=5: EX, then MEM, then WB.
        s = quiet(); s.id_valid = 1; s.rs1 = 5; s.u1 = 1; s.rf1 = 32'h99;
        s.exr = 32'hA; s.mem_rd = 5; s.mem_we = 1; s.mem_res = 32'hB;
        s.wb_rd = 5; s.wb_we = 1; s.wb_dat = 32'hC; s.rd = 6; s.rw = 0;
        drive_cycle(s);
        chk("prio_ex", ex_op1, 32'hA);
        drive_cycle(s);
        chk("prio_mem", ex_op1, 32'hB);
        s.mem_we = 0; s.rd = 0; s.rw = 1;
        drive_cycle(s);
        chk("prio_wb", ex_op1, 32'hC);
        s.rs1 = 0; s.rf1 = 32'h0; s.mem_rd = 0; s.mem_we = 1; s.wb_rd = 0;
        drive_cycle(s);
        chk("x0_no_bypass", ex_op1, 32'h0);

        // Load-use: lw x7 in EX, add reads rs2=7.
        s = quiet(); s.id_valid = 1; s.rd = 7; s.rw = 1; s.mr = 1;
        drive_cycle(s);
        s = quiet(); s.id_valid = 1; s.rs1 = 1; s.rs2 = 7; s.u1 = 1; s.u2 = 1;
        s.rf1 = 32'h5; s.rf2 = 32'hDEAD; s.rd = 8; s.rw = 1;
        drive_cycle(s);
        chk("lu_stall", {31'd0, stall_seen}, 32'd1);
        chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
        chk("lu_count", bubble_count, 32'd1);
        s.mem_rd = 7; s.mem_we = 1; s.mem_res = 32'h55;
        drive_cycle(s);
        chk("lu_resolve_stall", {31'd0, stall_seen}, 32'd0);
        chk("lu_resolve_op2", ex_op2, 32'h55);

        // Same hazard under flush: no stall, no count.
        s = quiet(); s.id_valid = 1; s.rd = 7; s.rw = 1; s.mr = 1;
        drive_cycle(s);
        s = quiet(); s.id_valid = 1; s.rs2 = 7; s.u2 = 1; s.flush = 1;
        drive_cycle(s);
        chk("flush_stall", {31'd0, stall_seen}, 32'd0);
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_count", bubble_count, 32'd1);

        // ex_hold for three cycles with changing decode, then release.
        s = quiet(); s.id_valid = 1; s.rs1 = 2; s.u1 = 1; s.rf1 = 32'h1234; s.rd = 3; s.rw = 1;
        drive_cycle(s);
        for (int i = 0; i < 3; i++) begin
            s = rand_stim(); s.rst = 0; s.hold = 1;
            drive_cycle(s);
            chk("hold_stall", {31'd0, stall_seen}, 32'd1);
            chk("hold_op1", ex_op1, 32'h1234);
        end
        s = quiet(); s.id_valid = 1; s.pc = 32'h200; s.imm = 32'hFFFF_FFF0; s.rd = 4;
        drive_cycle(s);
        chk("hold_release_pc", ex_pc, 32'h200);

        // Asynchronous reset between edges with valid state and a non-zero counter.
        s = quiet(); s.rst = 1;
        drive_cycle(s);

        // Counter wrap from all-ones.
        s = quiet(); s.id_valid = 1; s.rd = 9; s.rw = 1; s.mr = 1;
        drive_cycle(s);
        s = quiet(); s.id_valid = 1; s.rs1 = 9; s.u1 = 1; s.preload = 1;
        drive_cycle(s);
        chk("wrap_count", bubble_count, 32'd0);

        for (int i = 0; i < 400; i++) drive_cycle(rand_stim());

        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
